// File: rtl/msg_loader.sv
// Byte-serial message entry front end for the SHA-512 core: button conditioning, big-endian
// message assembly and start/done launch handshake. Debouncer enabled by MSG_LOADER_DEBOUNCE_EN.
module msg_loader #(
    parameter int unsigned MSG_BYTES       = 14,
    parameter int unsigned DEBOUNCE_CYCLES = 1250000
) (
    input  logic                               sysclk_125mhz,
    input  logic                               rst,
    input  logic [7:0]                         data_in,
    input  logic                               btn_push,
    input  logic                               btn_go,
    input  logic                               btn_clear,
    input  logic                               hash_done,
    output logic [8*MSG_BYTES-1:0]             msg,
    output logic [$clog2(MSG_BYTES+1)-1:0]     msg_count,
    output logic [7:0]                         last_byte,
    output logic                               full,
    output logic                               overflow,
    output logic                               hash_start,
    output logic                               digest_valid
);

    localparam int unsigned MSG_W     = 8 * MSG_BYTES;
    localparam int unsigned CNT_W     = $clog2(MSG_BYTES + 1);
    localparam int unsigned NUM_BTN   = 3;
    localparam int unsigned BTN_PUSH  = 0;
    localparam int unsigned BTN_GO    = 1;
    localparam int unsigned BTN_CLEAR = 2;

`ifdef MSG_LOADER_DEBOUNCE_EN
    localparam int unsigned     DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        ST_ENTRY,
        ST_START,
        ST_WAIT_DONE,
        ST_HOLD
    } state_t;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] ev_c;

    assign btn_raw = {btn_clear, btn_go, btn_push};

    // Per-button synchronizer, optional debouncer and rising-edge detector
    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        logic sync1_q, sync1_d;
        logic sync2_q, sync2_d;
        logic prev_q, prev_d;
        logic level;

`ifdef MSG_LOADER_DEBOUNCE_EN
        logic            acc_q, acc_d;
        logic [DB_W-1:0] cnt_q, cnt_d;

        // Accept a new level only after it has differed for DEBOUNCE_CYCLES straight cycles
        always_comb begin
            acc_d = acc_q;
            cnt_d = cnt_q;
            if (sync2_q == acc_q) begin
                cnt_d = '0;
            end else if (cnt_q == DB_LAST) begin
                acc_d = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + DB_W'(1);
            end
        end

        always_ff @(posedge sysclk_125mhz) begin
            if (!rst) begin
                acc_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                acc_q <= acc_d;
                cnt_q <= cnt_d;
            end
        end

        assign level = acc_q;
`else
        assign level = sync2_q;
`endif

        always_comb begin
            sync1_d = btn_raw[b];
            sync2_d = sync1_q;
            prev_d  = level;
        end

        always_ff @(posedge sysclk_125mhz) begin
            if (!rst) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                prev_q  <= 1'b0;
            end else begin
                sync1_q <= sync1_d;
                sync2_q <= sync2_d;
                prev_q  <= prev_d;
            end
        end

        assign ev_c[b] = level & ~prev_q;
    end

    state_t             state_q, state_d;
    logic [MSG_W-1:0]   msg_q, msg_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         last_q, last_d;
    logic               ovf_q, ovf_d;
    logic               dv_q, dv_d;
    logic               hs_q, hs_d;
    logic               full_c;

    assign full_c = (count_q == CNT_W'(MSG_BYTES));

    // Next state and message update; clear > go > push, lower events dropped
    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        count_d = count_q;
        last_d  = last_q;
        ovf_d   = ovf_q;
        dv_d    = dv_q;
        unique case (state_q)
            ST_ENTRY: begin
                if (ev_c[BTN_CLEAR]) begin
                    msg_d   = '0;
                    count_d = '0;
                    last_d  = '0;
                    ovf_d   = 1'b0;
                    dv_d    = 1'b0;
                end else if (ev_c[BTN_GO]) begin
                    if (count_q != '0) begin
                        state_d = ST_START;
                    end
                end else if (ev_c[BTN_PUSH]) begin
                    if (full_c) begin
                        ovf_d = 1'b1;
                    end else begin
                        for (int i = 0; i < int'(MSG_BYTES); i++) begin
                            if (count_q == CNT_W'(i)) begin
                                msg_d[MSG_W-1-8*i -: 8] = data_in;
                            end
                        end
                        last_d  = data_in;
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            ST_START: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (hash_done) begin
                    state_d = ST_HOLD;
                    dv_d    = 1'b1;
                end
            end
            ST_HOLD: begin
                if (ev_c[BTN_CLEAR]) begin
                    state_d = ST_ENTRY;
                    msg_d   = '0;
                    count_d = '0;
                    last_d  = '0;
                    ovf_d   = 1'b0;
                    dv_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_ENTRY;
            end
        endcase
        hs_d = (state_d == ST_START);
    end

    always_ff @(posedge sysclk_125mhz) begin
        if (!rst) begin
            state_q <= ST_ENTRY;
            msg_q   <= '0;
            count_q <= '0;
            last_q  <= '0;
            ovf_q   <= 1'b0;
            dv_q    <= 1'b0;
            hs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            count_q <= count_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
            dv_q    <= dv_d;
            hs_q    <= hs_d;
        end
    end

    assign msg          = msg_q;
    assign msg_count    = count_q;
    assign last_byte    = last_q;
    assign full         = full_c;
    assign overflow     = ovf_q;
    assign hash_start   = hs_q;
    assign digest_valid = dv_q;

endmodule

// File: tb/tb_msg_loader.sv
// Directed bench for msg_loader with MSG_BYTES=14, DEBOUNCE_CYCLES=4; latency follows
// MSG_LOADER_DEBOUNCE_EN so the same bench covers both builds.
module tb_msg_loader;

    localparam int unsigned MB     = 14;
    localparam int unsigned DB_CYC = 4;
`ifdef MSG_LOADER_DEBOUNCE_EN
    localparam int unsigned DB = DB_CYC;
`else
    localparam int unsigned DB = 0;
`endif
    localparam int unsigned LAT = 2 + DB;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    data_in = '0;
    logic          btn_push = 1'b0;
    logic          btn_go = 1'b0;
    logic          btn_clear = 1'b0;
    logic          hash_done = 1'b0;
    logic [111:0]  msg;
    logic [3:0]    msg_count;
    logic [7:0]    last_byte;
    logic          full;
    logic          overflow;
    logic          hash_start;
    logic          digest_valid;

    int total = 0;
    int bad = 0;
    int hs_count = 0;

    msg_loader #(.MSG_BYTES(MB), .DEBOUNCE_CYCLES(DB_CYC)) dut (
        .sysclk_125mhz(clk),
        .rst(rst),
        .data_in(data_in),
        .btn_push(btn_push),
        .btn_go(btn_go),
        .btn_clear(btn_clear),
        .hash_done(hash_done),
        .msg(msg),
        .msg_count(msg_count),
        .last_byte(last_byte),
        .full(full),
        .overflow(overflow),
        .hash_start(hash_start),
        .digest_valid(digest_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (hash_start === 1'b1) hs_count++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // btns: bit0 push, bit1 go, bit2 clear
    task automatic press(input logic [2:0] btns);
        {btn_clear, btn_go, btn_push} = btns;
        repeat (LAT + 4) tick();
        {btn_clear, btn_go, btn_push} = 3'b000;
        repeat (LAT + 4) tick();
    endtask

    task automatic push_byte(input logic [7:0] b);
        data_in = b;
        press(3'b001);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        total++; if (msg !== 112'h0) begin bad++; $display("FAIL reset_msg: got %h exp 0", msg); end
        total++; if (msg_count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d exp 0", msg_count); end
        total++; if (last_byte !== 8'h00) begin bad++; $display("FAIL reset_last: got %h exp 00", last_byte); end
        total++; if ({full, overflow, hash_start, digest_valid} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got %b exp 0000", {full, overflow, hash_start, digest_valid});
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        data_in = 8'hA5;
        btn_push = 1'b1;
        for (int k = 1; k <= int'(LAT) + 1; k++) begin
            tick();
            if (k == int'(LAT)) begin
                total++; if (msg_count !== 4'd0) begin bad++; $display("FAIL lat_early: got %0d exp 0", msg_count); end
            end
            if (k == int'(LAT) + 1) begin
                total++; if (msg_count !== 4'd1) begin bad++; $display("FAIL lat_update: got %0d exp 1", msg_count); end
                total++; if (last_byte !== 8'hA5) begin bad++; $display("FAIL lat_last: got %h exp a5", last_byte); end
            end
        end
        btn_push = 1'b0;
        repeat (LAT + 4) tick();
        press(3'b100);
        total++; if (msg_count !== 4'd0) begin bad++; $display("FAIL lat_clear: got %0d exp 0", msg_count); end
    endtask

    task automatic test_fill_overflow();
        logic [111:0] hello;
        hello = 112'h48656c6c6f205348412d35313221;
        for (int i = 0; i < int'(MB); i++) push_byte(hello[111-8*i -: 8]);
        total++; if (msg !== hello) begin bad++; $display("FAIL fill_msg: got %h exp %h", msg, hello); end
        total++; if (msg_count !== 4'd14) begin bad++; $display("FAIL fill_count: got %0d exp 14", msg_count); end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full: got %b exp 1", full); end
        total++; if (last_byte !== 8'h21) begin bad++; $display("FAIL fill_last: got %h exp 21", last_byte); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_ovf: got %b exp 0", overflow); end
        push_byte(8'h58);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b exp 1", overflow); end
        total++; if (msg !== hello) begin bad++; $display("FAIL ovf_msg: got %h exp %h", msg, hello); end
        total++; if (msg_count !== 4'd14) begin bad++; $display("FAIL ovf_count: got %0d exp 14", msg_count); end
        total++; if (last_byte !== 8'h21) begin bad++; $display("FAIL ovf_last: got %h exp 21", last_byte); end
        press(3'b100);
        total++; if (msg !== 112'h0) begin bad++; $display("FAIL clr_msg: got %h exp 0", msg); end
        total++; if ({msg_count, last_byte} !== 12'h000) begin
            bad++; $display("FAIL clr_count_last: got %h exp 000", {msg_count, last_byte});
        end
        total++; if ({full, overflow} !== 2'b00) begin bad++; $display("FAIL clr_flags: got %b exp 00", {full, overflow}); end
    endtask

    task automatic test_go_empty();
        int h0;
        h0 = hs_count;
        press(3'b010);
        total++; if (hs_count !== h0) begin bad++; $display("FAIL go_empty_hs: got %0d exp %0d", hs_count, h0); end
        push_byte(8'h11);
        total++; if (msg_count !== 4'd1) begin bad++; $display("FAIL go_empty_entry: got %0d exp 1", msg_count); end
        press(3'b100);
    endtask

    task automatic test_launch();
        bit found;
        int h0;
        push_byte(8'h61);
        push_byte(8'h62);
        push_byte(8'h63);
        btn_go = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (hash_start === 1'b1) found = 1'b1;
        end
        btn_go = 1'b0;
        total++; if (!found) begin bad++; $display("FAIL launch_start: got no hash_start exp pulse"); end
        total++; if (msg[111:88] !== 24'h616263) begin bad++; $display("FAIL launch_msg_hi: got %h exp 616263", msg[111:88]); end
        total++; if (msg[87:0] !== 88'h0) begin bad++; $display("FAIL launch_msg_lo: got %h exp 0", msg[87:0]); end
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) begin
                total++; if (hash_start !== 1'b0) begin bad++; $display("FAIL start_width: got %b exp 0", hash_start); end
            end
            total++; if (digest_valid !== 1'b0) begin bad++; $display("FAIL dv_early k=%0d: got %b exp 0", k, digest_valid); end
        end
        hash_done = 1'b1;
        tick();
        total++; if (digest_valid !== 1'b1) begin bad++; $display("FAIL dv_rise: got %b exp 1", digest_valid); end
        h0 = hs_count;
        push_byte(8'h7a);
        press(3'b010);
        total++; if ({msg_count, last_byte} !== 12'h363) begin
            bad++; $display("FAIL hold_push: got %h exp 363", {msg_count, last_byte});
        end
        total++; if (hs_count !== h0) begin bad++; $display("FAIL hold_go: got %0d exp %0d", hs_count, h0); end
        total++; if (digest_valid !== 1'b1) begin bad++; $display("FAIL hold_dv: got %b exp 1", digest_valid); end
        hash_done = 1'b0;
        press(3'b100);
        total++; if ({digest_valid, msg_count} !== 5'h00) begin
            bad++; $display("FAIL hold_clear: got %h exp 00", {digest_valid, msg_count});
        end
    endtask

    task automatic test_simultaneous();
        int h0;
        push_byte(8'h01);
        push_byte(8'h02);
        press(3'b101);
        total++; if (msg_count !== 4'd0) begin bad++; $display("FAIL sim_clear_push: got %0d exp 0", msg_count); end
        total++; if (msg !== 112'h0) begin bad++; $display("FAIL sim_clear_msg: got %h exp 0", msg); end
        push_byte(8'h01);
        push_byte(8'h02);
        h0 = hs_count;
        press(3'b011);
        total++; if (msg_count !== 4'd2) begin bad++; $display("FAIL sim_go_push: got %0d exp 2", msg_count); end
        total++; if (hs_count !== h0 + 1) begin bad++; $display("FAIL sim_go_launch: got %0d exp %0d", hs_count, h0 + 1); end
        hash_done = 1'b1;
        repeat (3) tick();
        total++; if (digest_valid !== 1'b1) begin bad++; $display("FAIL sim_dv: got %b exp 1", digest_valid); end
        hash_done = 1'b0;
        press(3'b100);
    endtask

`ifdef MSG_LOADER_DEBOUNCE_EN
    task automatic test_bounce();
        data_in = 8'h42;
        for (int i = 0; i < 20; i++) begin
            btn_push = ((i / 2) % 2 == 0);
            tick();
        end
        btn_push = 1'b1;
        repeat (LAT + 6) tick();
        btn_push = 1'b0;
        repeat (LAT + 6) tick();
        total++; if (msg_count !== 4'd1) begin bad++; $display("FAIL bounce_count: got %0d exp 1", msg_count); end
        total++; if (msg[111:104] !== 8'h42) begin bad++; $display("FAIL bounce_byte: got %h exp 42", msg[111:104]); end
        press(3'b100);
    endtask
`endif

    task automatic test_reset_wait();
        bit found;
        int h0;
        push_byte(8'h5a);
        btn_go = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (hash_start === 1'b1) found = 1'b1;
        end
        btn_go = 1'b0;
        total++; if (!found) begin bad++; $display("FAIL rw_start: got no hash_start exp pulse"); end
        tick();
        rst = 1'b0;
        tick();
        total++; if ({msg, msg_count, last_byte} !== 124'h0) begin
            bad++; $display("FAIL rw_data: got %h exp 0", {msg, msg_count, last_byte});
        end
        total++; if ({full, overflow, hash_start, digest_valid} !== 4'b0000) begin
            bad++; $display("FAIL rw_flags: got %b exp 0000", {full, overflow, hash_start, digest_valid});
        end
        rst = 1'b1;
        hash_done = 1'b1;
        h0 = hs_count;
        repeat (6) tick();
        total++; if (digest_valid !== 1'b0) begin bad++; $display("FAIL rw_done_ignored: got %b exp 0", digest_valid); end
        total++; if (hs_count !== h0) begin bad++; $display("FAIL rw_no_start: got %0d exp %0d", hs_count, h0); end
        hash_done = 1'b0;
        push_byte(8'h33);
        total++; if ({msg_count, msg[111:104]} !== 12'h133) begin
            bad++; $display("FAIL rw_entry: got %h exp 133", {msg_count, msg[111:104]});
        end
        press(3'b100);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill_overflow();
        test_go_empty();
        test_launch();
        test_simultaneous();
`ifdef MSG_LOADER_DEBOUNCE_EN
        test_bounce();
`endif
        test_reset_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
